fwd_scoreboard: RTL
===================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised forwarding/interlock unit for the pipelined MIPS core; successor to the fixed-stage
//  combinational forwarding decoder. Tracks every in-flight register writer in a DEPTH-slot shift
//  register (slot 1 = E, slot 2 = M, slot 3 = W, ...). Generates per-source forward selects and
//  a D-stage stall for NSRC source-register channels.
// PARAMETERS
//  DEPTH  3  number of post-decode slots tracked (E..W); minimum 1
//  AW     5  register address width
//  NSRC   2  number of D-stage source channels (rs, rt, ...)
//  SW     2  slot-index width; must be >= $clog2(DEPTH+1)
// PORTS
//  clk         in   1        rising-edge clock
//  reset_n     in   1        asynchronous, active-low reset
//  issue_valid in   1        instruction in D is real (not a bubble)
//  issue_we    in   1        D instruction writes a register
//  issue_dst   in   AW       D instruction destination register
//  issue_rdy   in   SW       slot index whose output register first holds the result (1=E, 2=M(load), ...)
//  flush       in   1        discard D instruction: slot 1 loads a bubble next edge
//  src_addr    in   NSRC*AW  channel i source register = src_addr[i*AW +: AW]
//  fwd_sel     out  NSRC*SW  channel i select: 0 = GRF, k = forward from slot k output
//  stall       out  1        freeze PC/FD; insert bubble into slot 1
//  stall_cnt   out  32       stall-cycle counter (present only with FWD_STALL_CNT_EN)
// BEHAVIOUR
//  - Slot k state: v, we, dst[AW], rdy[SW]. Reset (async, reset_n=0): all v=0; stall=0, fwd_sel=0
//    (combinational outputs of cleared state). stall_cnt=0.
//  - Edge update: slots k=2..DEPTH <= slot k-1 every cycle (never frozen; downstream always drains).
//    Slot 1 <= {issue_valid,issue_we,issue_dst,issue_rdy} when !stall && !flush; else bubble (v=0).
//    Slot DEPTH contents are dropped at the next edge (written to GRF).
//  - Match for channel i: slot k with v && we && dst==src_i && dst!=0. $0 never matches.
//  - Priority: youngest (lowest k) match wins; older matches to same register are ignored.
//  - No match -> fwd_sel_i = 0. Match at k with rdy <= k -> fwd_sel_i = k, no stall contribution.
//    Match at k with rdy > k -> stall contribution; fwd_sel_i = 0 (don't-care, driven 0).
//  - stall = OR of all channel contributions, combinational, same cycle as src_addr.
//  - Load-use (rdy=2) directly behind: 1 stall cycle, then match at slot 2, fwd_sel=2.
//  - Stall and flush together: flush wins for slot 1 (bubble either way); stall still asserted.
//  - Zero latency: fwd_sel/stall are pure functions of current slot state and inputs.
//  - issue_* ignored when issue_valid=0; issue_rdy=0 treated as 1.
// CONFIGURATION
//  FWD_STALL_CNT_EN defined: stall_cnt port exists; increments by 1 on every edge with stall=1,
//    saturates at 32'hFFFF_FFFF, cleared only by reset_n.
//  Not defined: port and counter absent; no other behaviour changes.
// TESTING (DEPTH=3, NSRC=2)
//  1 issue addu dst=1 rdy=1; next cycle src0=1 -> fwd_sel0=1, stall=0; cycle after -> fwd_sel0=2.
//  2 issue lw dst=1 rdy=2; next cycle src1=1 -> stall=1, fwd_sel1=0; next cycle slot1 bubble,
//    stall=0, fwd_sel1=2.
//  3 issue dst=0 we=1 rdy=1; next cycle src0=0 -> fwd_sel0=0, stall=0.
//  4 issue dst=1 rdy=1 twice in a row; then src0=1 -> fwd_sel0=1 (youngest), not 2.
//  5 slots 1..3 valid dst=2,3,4; pulse reset_n low mid-cycle -> immediately fwd_sel=0, stall=0;
//    src0=3 after release -> fwd_sel0=0.
//  6 issue dst=5 with flush=1; next cycle src0=5 -> fwd_sel0=0; with macro, 2 stall cycles -> stall_cnt=2.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - DEPTH-slot writer scoreboard producing forward selects and D-stage stall
// Optional feature macro: FWD_STALL_CNT_EN (adds the stall_cnt saturating stall-cycle counter)
module fwd_scoreboard #(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int SW    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               issue_valid,
  input  logic               issue_we,
  input  logic [AW-1:0]      issue_dst,
  input  logic [SW-1:0]      issue_rdy,
  input  logic               flush,
  input  logic [NSRC*AW-1:0] src_addr,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic               stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  // Array index k holds pipeline slot k+1 (index 0 = E).
  logic [DEPTH-1:0] slot_v;
  logic [DEPTH-1:0] slot_we;
  logic [AW-1:0]    slot_dst [DEPTH];
  logic [SW-1:0]    slot_rdy [DEPTH];

  // A ready slot of 0 would never be reached, so it is normalised to E on capture.
  logic [SW-1:0] issue_rdy_norm;
  assign issue_rdy_norm = (issue_rdy == '0) ? SW'(1) : issue_rdy;

  // Slot shift register: slot 1 captures D (or a bubble), older slots always drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_v  <= '0;
      slot_we <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_dst[k] <= '0;
        slot_rdy[k] <= '0;
      end
    end else begin
      slot_v[0]   <= issue_valid && !stall && !flush;
      slot_we[0]  <= issue_we;
      slot_dst[0] <= issue_dst;
      slot_rdy[0] <= issue_rdy_norm;
      for (int k = 1; k < DEPTH; k++) begin
        slot_v[k]   <= slot_v[k-1];
        slot_we[k]  <= slot_we[k-1];
        slot_dst[k] <= slot_dst[k-1];
        slot_rdy[k] <= slot_rdy[k-1];
      end
    end
  end

  // Per channel: youngest matching writer decides forward slot or interlock.
  always_comb begin : fwd_decode
    logic [AW-1:0] src;
    logic          hit;
    logic [SW-1:0] sel;
    logic          stl;
    fwd_sel = '0;
    stall   = 1'b0;
    src     = '0;
    hit     = 1'b0;
    sel     = '0;
    stl     = 1'b0;
    for (int ch = 0; ch < NSRC; ch++) begin
      src = src_addr[ch*AW +: AW];
      hit = 1'b0;
      sel = '0;
      stl = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && slot_v[k] && slot_we[k] && (slot_dst[k] == src) && (src != '0)) begin
          hit = 1'b1;
          if (slot_rdy[k] <= SW'(k + 1)) sel = SW'(k + 1);
          else                           stl = 1'b1;
        end
      end
      fwd_sel[ch*SW +: SW] = sel;
      stall = stall | stl;
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Saturating count of edges seen with stall asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
